// File: rtl/writeback_regfile.sv
// Writeback result select, 32x32 architectural register file and commit counter.
// Optional same-cycle write-through bypass on both read ports: REGFILE_BYPASS_EN.
module writeback_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultW,
  input  logic [31:0] ReadDataW,
  input  logic [31:0] PCPlus4W,
  input  logic [4:0]  RdW,
  input  logic [1:0]  ResultSrcW,
  input  logic        RegWriteW,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  output logic [31:0] ResultW,
  output logic [31:0] RD1D,
  output logic [31:0] RD2D,
  output logic [31:0] WbCountW
);

  logic [31:0] r_regs [32];
  logic [31:0] r_wb_count;
  logic [31:0] w_result;
  logic        w_commit;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;

  always_comb begin
    w_result = ALUResultW;
    unique case (ResultSrcW)
      2'b01:   w_result = ReadDataW;
      2'b10:   w_result = PCPlus4W;
      default: w_result = ALUResultW;
    endcase
  end

  // A reset cycle never commits, even with RegWriteW high.
  assign w_commit = RegWriteW && (RdW != 5'd0) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
      r_wb_count <= '0;
    end else if (w_commit) begin
      r_regs[RdW] <= w_result;
      r_wb_count  <= r_wb_count + 32'd1;
    end
  end

  always_comb begin
    w_rd1 = r_regs[Rs1D];
    w_rd2 = r_regs[Rs2D];
`ifdef REGFILE_BYPASS_EN
    if (w_commit && (RdW == Rs1D)) w_rd1 = w_result;
    if (w_commit && (RdW == Rs2D)) w_rd2 = w_result;
`endif
    if (Rs1D == 5'd0) w_rd1 = '0;
    if (Rs2D == 5'd0) w_rd2 = '0;
  end

  assign ResultW  = w_result;
  assign RD1D     = w_rd1;
  assign RD2D     = w_rd2;
  assign WbCountW = r_wb_count;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile against an array/counter model.
// Honours REGFILE_BYPASS_EN for same-cycle read expectations.
module tb_writeback_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic [4:0]  RdW;
  logic [1:0]  ResultSrcW;
  logic        RegWriteW;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [31:0] ResultW;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [31:0] WbCountW;

  int n_tests;
  int n_fail;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  writeback_regfile dut (
    .clk(clk), .rst(rst),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .PCPlus4W(PCPlus4W), .RdW(RdW),
    .ResultSrcW(ResultSrcW), .RegWriteW(RegWriteW),
    .Rs1D(Rs1D), .Rs2D(Rs2D),
    .ResultW(ResultW), .RD1D(RD1D),
    .RD2D(RD2D), .WbCountW(WbCountW)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_res();
    case (ResultSrcW)
      2'b01:   return ReadDataW;
      2'b10:   return PCPlus4W;
      default: return ALUResultW;
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (!rst && RegWriteW && RdW == idx) return exp_res();
`endif
    return m_regs[idx];
  endfunction

  task automatic drive(input logic r, input logic we, input logic [4:0] rd,
                       input logic [1:0] src, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [31:0] pc4,
                       input logic [4:0] s1, input logic [4:0] s2);
    @(negedge clk);
    rst = r; RegWriteW = we; RdW = rd; ResultSrcW = src;
    ALUResultW = alu; ReadDataW = ld; PCPlus4W = pc4;
    Rs1D = s1; Rs2D = s2;
    #1;
  endtask

  task automatic tick();
    logic [31:0] v;
    v = exp_res();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 32'd0;
    end else if (RegWriteW && RdW != 0) begin
      m_regs[RdW] = v;
      m_cnt = m_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(0, 1, 5'd5, 2'b00, 32'h5555, 0, 0, 5'd5, 5'd6);
    tick();
    drive(0, 1, 5'd6, 2'b00, 32'h6666, 0, 0, 5'd5, 5'd6);
    tick();
    drive(1, 1, 5'd5, 2'b00, 32'h9999, 0, 0, 5'd5, 5'd6);
    tick();
    drive(0, 0, 5'd0, 2'b00, 0, 0, 0, 5'd0, 5'd0);
    n_tests++;
    if (WbCountW !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_count got %h want 0", WbCountW);
    end
    for (int i = 1; i < 32; i++) begin
      Rs1D = 5'(i); Rs2D = 5'(31 - i + 1);
      #1;
      n_tests++;
      if (RD1D !== 32'd0 || RD2D !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_x%0d got %h/%h want 0", i, RD1D, RD2D);
      end
    end
  endtask

  task automatic test_result_select();
    logic [31:0] want [4];
    want[0] = 32'h11; want[1] = 32'h22; want[2] = 32'h33; want[3] = 32'h11;
    for (int s = 0; s < 4; s++) begin
      drive(0, 1, 5'(s + 1), 2'(s), 32'h11, 32'h22, 32'h33, 5'd0, 5'd0);
      n_tests++;
      if (ResultW !== want[s]) begin
        n_fail++;
        $display("FAIL result_sel%0d got %h want %h", s, ResultW, want[s]);
      end
      tick();
    end
    drive(0, 0, 5'd0, 2'b00, 0, 0, 0, 5'd1, 5'd2);
    for (int s = 0; s < 4; s += 2) begin
      Rs1D = 5'(s + 1); Rs2D = 5'(s + 2);
      #1;
      n_tests++;
      if (RD1D !== want[s] || RD2D !== want[s + 1]) begin
        n_fail++;
        $display("FAIL sel_read_x%0d got %h/%h want %h/%h",
                 s + 1, RD1D, RD2D, want[s], want[s + 1]);
      end
    end
    n_tests++;
    if (WbCountW !== 32'd4) begin
      n_fail++;
      $display("FAIL sel_count got %0d want 4", WbCountW);
    end
  endtask

  task automatic test_x0();
    logic [31:0] c0;
    c0 = m_cnt;
    drive(0, 1, 5'd0, 2'b00, 32'hDEADBEEF, 0, 0, 5'd0, 5'd0);
    n_tests++;
    if (RD1D !== 32'd0 || ResultW !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL x0_same got %h res %h want 0", RD1D, ResultW);
    end
    tick();
    drive(0, 0, 5'd0, 2'b00, 0, 0, 0, 5'd0, 5'd0);
    n_tests++;
    if (RD1D !== 32'd0 || WbCountW !== c0) begin
      n_fail++;
      $display("FAIL x0_after got %h cnt %0d want 0 cnt %0d",
               RD1D, WbCountW, c0);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] same;
`ifdef REGFILE_BYPASS_EN
    same = 32'hA5A5A5A5;
`else
    same = 32'h5;
`endif
    drive(0, 1, 5'd7, 2'b00, 32'h5, 0, 0, 5'd0, 5'd0);
    tick();
    drive(0, 1, 5'd7, 2'b01, 0, 32'hA5A5A5A5, 0, 5'd7, 5'd7);
    n_tests++;
    if (RD1D !== same || RD2D !== same) begin
      n_fail++;
      $display("FAIL bypass_same got %h/%h want %h", RD1D, RD2D, same);
    end
    tick();
    drive(0, 0, 5'd0, 2'b00, 0, 0, 0, 5'd7, 5'd7);
    n_tests++;
    if (RD1D !== 32'hA5A5A5A5 || RD2D !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL bypass_next got %h/%h want a5a5a5a5", RD1D, RD2D);
    end
  endtask

  task automatic test_no_write();
    logic [31:0] c0;
    logic [31:0] old9;
    c0 = m_cnt;
    old9 = m_regs[9];
    drive(0, 0, 5'd9, 2'b00, 32'h1234, 0, 0, 5'd9, 5'd0);
    n_tests++;
    if (RD1D !== old9) begin
      n_fail++;
      $display("FAIL nowrite_same got %h want %h", RD1D, old9);
    end
    tick();
    drive(0, 0, 5'd0, 2'b00, 0, 0, 0, 5'd9, 5'd0);
    n_tests++;
    if (RD1D !== old9 || WbCountW !== c0) begin
      n_fail++;
      $display("FAIL nowrite got %h cnt %0d want %h cnt %0d",
               RD1D, WbCountW, old9, c0);
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 1, 5'd12, 2'b00, 32'h100, 0, 0, 5'd0, 5'd0);
    tick();
    drive(0, 1, 5'd12, 2'b10, 0, 0, 32'h200, 5'd0, 5'd0);
    tick();
    drive(0, 1, 5'd12, 2'b11, 32'h300, 0, 0, 5'd0, 5'd0);
    tick();
    drive(0, 0, 5'd0, 2'b00, 0, 0, 0, 5'd12, 5'd0);
    n_tests++;
    if (RD1D !== 32'h300 || WbCountW !== m_cnt) begin
      n_fail++;
      $display("FAIL b2b got %h cnt %0d want 300 cnt %0d",
               RD1D, WbCountW, m_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    @(negedge clk);
    force dut.r_wb_count = 32'hFFFFFFFF;
    #1;
    release dut.r_wb_count;
    m_cnt = 32'hFFFFFFFF;
    drive(0, 1, 5'd3, 2'b00, 32'h77, 0, 0, 5'd0, 5'd0);
    n_tests++;
    if (WbCountW !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL wrap_pre got %h want ffffffff", WbCountW);
    end
    tick();
    drive(0, 0, 5'd0, 2'b00, 0, 0, 0, 5'd3, 5'd0);
    n_tests++;
    if (WbCountW !== 32'd0 || RD1D !== 32'h77) begin
      n_fail++;
      $display("FAIL wrap got %h x3 %h want 0 x3 77", WbCountW, RD1D);
    end
  endtask

  task automatic test_random();
    logic [4:0] rd;
    logic [4:0] s1;
    logic [4:0] s2;
    logic       r;
    logic [31:0] e1;
    logic [31:0] e2;
    for (int n = 0; n < 400; n++) begin
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      s1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
      s2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
      r = ($urandom_range(0, 63) == 0);
      drive(r, 1'($urandom_range(0, 3) != 0), rd, 2'($urandom),
            $urandom, $urandom, $urandom, s1, s2);
      n_tests++;
      if (ResultW !== exp_res()) begin
        n_fail++;
        $display("FAIL rnd_res%0d got %h want %h", n, ResultW, exp_res());
      end
      if (!r) begin
        e1 = exp_rd(s1);
        e2 = exp_rd(s2);
        n_tests++;
        if (RD1D !== e1 || RD2D !== e2 || WbCountW !== m_cnt) begin
          n_fail++;
          $display("FAIL rnd_rd%0d got %h/%h cnt %0d want %h/%h cnt %0d",
                   n, RD1D, RD2D, WbCountW, e1, e2, m_cnt);
        end
      end
      tick();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_cnt = 32'd0;
    rst = 1; RegWriteW = 0; RdW = 0; ResultSrcW = 0;
    ALUResultW = 0; ReadDataW = 0; PCPlus4W = 0; Rs1D = 0; Rs2D = 0;
    tick();
    tick();
    test_reset();
    test_result_select();
    test_x0();
    test_bypass();
    test_no_write();
    test_back_to_back();
    test_counter_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Writeback stage and architectural register file of the five-stage pipeline. Consumes the MEM/WB pipeline register outputs, selects the writeback result, and commits it to a 32 x 32-bit register file. Provides two asynchronous read ports to the decode stage and a 32-bit writeback-commit counter. Sits between the MEM/WB register and the decode stage, closing the pipeline loop.

## Interface
- No parameters; XLEN is 32 and register count is 32, both fixed.
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ALUResultW  input  32  ALU result from MEM/WB.
- ReadDataW  input  32  load data from MEM/WB.
- PCPlus4W  input  32  link address from MEM/WB.
- RdW  input  5  destination register index.
- ResultSrcW  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 ALU (reserved).
- RegWriteW  input  1  write enable for this writeback.
- Rs1D  input  5  decode read port 1 index.
- Rs2D  input  5  decode read port 2 index.
- ResultW  output  32  selected writeback value, combinational; also feeds EX forwarding.
- RD1D  output  32  read data for Rs1D.
- RD2D  output  32  read data for Rs2D.
- WbCountW  output  32  number of committed register writes since reset.

## Operation
- ResultW = mux(ResultSrcW): 00/11 -> ALUResultW, 01 -> ReadDataW, 10 -> PCPlus4W. Purely combinational; no state.
- Commit condition: RegWriteW == 1 and RdW != 0. On commit, regs[RdW] <= ResultW at the rising edge.
- x0: never written; RD1D/RD2D return 32'd0 whenever the corresponding index is 0, regardless of any write.
- Reads are combinational from the array: RDnD = regs[RsnD], subject to x0 and bypass rules.
- Bypass (when compiled in, see Configuration): if commit condition holds and RdW == RsnD, RDnD = ResultW in the same cycle (write-before-read).
- WbCountW increments by 1 on every commit; writes to x0 and RegWriteW=0 cycles do not count. Wraps modulo 2^32 (0xFFFFFFFF -> 0x00000000).
- Both read ports are independent; Rs1D == Rs2D == RdW bypasses both.

## Timing
- Reset (rst=1 at rising edge): all 32 registers <= 0, WbCountW <= 0. Writeback inputs are ignored in a reset cycle; no commit occurs even if RegWriteW=1.
- Outputs after reset: RD1D = RD2D = 0 for any index, WbCountW = 0; ResultW follows inputs (combinational).
- Write latency: value visible in array one cycle after the commit edge; with bypass it is visible on RDnD in the commit cycle itself.
- Reset asserted mid-stream: the cycle's in-flight write is dropped; registers restored to 0 on that edge.
- Back-to-back writes to the same RdW: last write wins; each increments WbCountW.
- No handshake; no stall input. Write happens whenever the commit condition holds at the edge.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write-through bypass on both read ports as described; hazard unit needs no extra stall for a WB->ID dependency.
- REGFILE_BYPASS_EN undefined: RDnD always returns the pre-edge array content; reading RdW in its commit cycle returns the old value, and the hazard unit must stall decode one cycle for WB->ID dependencies. All other behaviour identical.

## Test plan
- Reset: preload via writes, assert rst one cycle with RegWriteW=1, RdW=5 -> after edge all RDnD = 0 for indices 1..31, WbCountW = 0, x5 not written.
- Result select: ALUResultW=0x11, ReadDataW=0x22, PCPlus4W=0x33, ResultSrcW 00/01/10/11 -> ResultW 0x11/0x22/0x33/0x11; commit each to x1..x4 -> reads return those values, WbCountW = 4.
- x0: RegWriteW=1, RdW=0, ResultW=0xDEADBEEF -> RD1D with Rs1D=0 reads 0 in and after the cycle; WbCountW unchanged.
- Bypass: x7=0x5, then commit 0xA5A5A5A5 to x7 with Rs1D=Rs2D=7 -> same cycle RD1D=RD2D=0xA5A5A5A5 (macro on) or 0x5 (macro off); next cycle 0xA5A5A5A5 in both builds.
- RegWriteW=0 with RdW=9, ResultW=0x1234 -> x9 unchanged, WbCountW unchanged.
- Counter wrap: drive 2^32 commits (or force counter to 0xFFFFFFFF in bench) then one commit -> WbCountW = 0.
